// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter using the open-drain request-to-send sequence.
// Optional build macro PS2_TX_RETRY_EN: retry a failed byte up to twice before reporting tx_error.
module ps2_host_tx #(
    parameter int unsigned SYS_FREQ         = 100_000_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned BIT_TIMEOUT_US   = 2000
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [3:0] dbg_state
);

    localparam int unsigned CYC_PER_US = SYS_FREQ / 1_000_000;
    localparam int unsigned INH_CYC    = CYC_PER_US * INHIBIT_US;
    localparam int unsigned START_CYC  = CYC_PER_US * START_TIMEOUT_US;
    localparam int unsigned BIT_CYC    = CYC_PER_US * BIT_TIMEOUT_US;
    localparam int unsigned MAX_CYC    =
        (START_CYC > BIT_CYC) ? ((START_CYC > INH_CYC) ? START_CYC : INH_CYC)
                              : ((BIT_CYC > INH_CYC) ? BIT_CYC : INH_CYC);
    localparam int TMR_W = $clog2(MAX_CYC + 1);

    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INH_CYC - 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] BIT_LAST   = TMR_W'(BIT_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_FIRST,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [3:0]         edge_cnt;
    logic [10:0]        frame_q;
    logic [10:0]        shift;
    logic [1:0]         clk_sync;
    logic [1:0]         data_sync;
    logic               clk_prev;
    logic               clk_s;
    logic               data_s;
    logic               fall;
    logic               fail;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]         attempt;
`endif

    assign dbg_state = state;
    assign clk_s     = clk_sync[1];
    assign data_s    = data_sync[1];
    assign fall      = clk_prev & ~clk_s;

    // Pins idle high through the pull-ups, so the synchronizers reset to 1.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    always_comb begin
        fail = 1'b0;
        case (state)
            S_WAIT_FIRST: fail = !fall && (timer == START_LAST);
            S_SEND:       fail = !fall && (timer == BIT_LAST);
            S_ACK:        fail = fall ? data_s : (timer == BIT_LAST);
            S_WAIT_IDLE:  fail = !(clk_s && data_s) && (timer == BIT_LAST);
            default:      fail = 1'b0;
        endcase
    end

    // Handshake: a byte is taken on any clk edge where tx_valid && tx_ready;
    // tx_ready is high only in IDLE and requests arriving while busy are dropped.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timer       <= '0;
            edge_cnt    <= 4'd0;
            frame_q     <= 11'd0;
            shift       <= 11'd0;
`ifdef PS2_TX_RETRY_EN
            attempt     <= 2'd0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            timer    <= timer + TMR_W'(1);
            if (fail) begin
`ifdef PS2_TX_RETRY_EN
                if (attempt != 2'd2) begin
                    attempt     <= attempt + 2'd1;
                    state       <= S_INHIBIT;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= 1'b0;
                    timer       <= '0;
                    edge_cnt    <= 4'd0;
                end else
`endif
                begin
                    state       <= S_ERROR;
                    tx_error    <= 1'b1;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        timer       <= '0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_valid) begin
                            // Frame word: start(0) in bit 0, then data LSB first, odd parity, stop(1).
                            frame_q    <= {1'b1, ~^tx_data, tx_data, 1'b0};
                            tx_ready   <= 1'b0;
                            tx_busy    <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            edge_cnt   <= 4'd0;
                            state      <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            attempt    <= 2'd0;
`endif
                        end
                    end
                    S_INHIBIT: begin
                        if (timer == INH_LAST) begin
                            ps2_data_oe <= 1'b1;
                            shift       <= frame_q;
                            state       <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        ps2_clk_oe <= 1'b0;
                        timer      <= '0;
                        state      <= S_WAIT_FIRST;
                    end
                    S_WAIT_FIRST: begin
                        if (fall) begin
                            edge_cnt    <= 4'd1;
                            ps2_data_oe <= ~shift[1];
                            shift       <= {1'b1, shift[10:1]};
                            timer       <= '0;
                            state       <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (fall) begin
                            edge_cnt    <= edge_cnt + 4'd1;
                            ps2_data_oe <= ~shift[1];
                            shift       <= {1'b1, shift[10:1]};
                            timer       <= '0;
                            // Edge 10 puts the stop bit out; the next edge carries the ACK.
                            if (edge_cnt == 4'd9) begin
                                state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (fall) begin
                            edge_cnt <= 4'd11;
                            timer    <= '0;
                            state    <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_s && data_s) begin
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                    S_DONE, S_ERROR: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_ready    <= 1'b1;
                        tx_busy     <= 1'b0;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a 12.5 kHz PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int HALF      = 40;
  localparam int START_CYC = 15000;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic [3:0] dbg_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int inh_phases = 0;
  int rel_cyc = 0;
  int err_cyc = 0;
  logic clk_oe_q = 1'b0;
  logic err_q = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.SYS_FREQ(1_000_000)) dut (
    .clk(clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // bus monitor, sampled on the inactive edge
  always @(negedge clk) begin
    cyc++;
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_error && !err_q) err_cyc = cyc;
    if (ps2_clk_oe && !clk_oe_q) inh_phases++;
    if (!ps2_clk_oe && clk_oe_q) rel_cyc = cyc;
    clk_oe_q = ps2_clk_oe;
    err_q = tx_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_request(output int inh_len, output logic ok);
    int n;
    n = 0;
    inh_len = 0;
    while (!ps2_clk_oe && n < 500) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk_oe && inh_len < 2000) begin
      @(negedge clk);
      inh_len++;
    end
    ok = (inh_len > 0) && !ps2_clk_oe;
  endtask

  task automatic dev_bit(output logic b);
    dev_clk_low = 1'b1;
    cycles(HALF);
    dev_clk_low = 1'b0;
    #1 b = ps2_data_in;
    cycles(HALF);
  endtask

  task automatic dev_frame(input logic ack_bit, output logic [9:0] rx);
    logic b;
    cycles(50);
    for (int k = 0; k < 10; k++) begin
      dev_bit(b);
      rx[k] = b;
    end
    dev_data_low = ~ack_bit;
    cycles(5);
    dev_clk_low = 1'b1;
    cycles(HALF);
    dev_clk_low = 1'b0;
    cycles(HALF);
    dev_data_low = 1'b0;
  endtask

  initial begin
    int len;
    logic ok;
    logic b;
    logic [9:0] rx;
    int d0, e0, ph0, n;
    logic [7:0] bb_byte [2];
    logic       bb_par [2];
    bb_byte[0] = 8'h01; bb_par[0] = 1'b0;
    bb_byte[1] = 8'h00; bb_par[1] = 1'b1;

    // reset values
    cycles(3);
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    sys_rst = 1'b0;
    cycles(5);

    // 0xED set-LEDs with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    check("ed_busy", tx_busy, 1);
    check("ed_ready_low", tx_ready, 0);
    wait_request(len, ok);
    check("ed_request", ok, 1);
    check("ed_inhibit_ge120", len >= 120, 1);
    check("ed_start_bit", ps2_data_in, 0);
    dev_frame(1'b0, rx);
    check("ed_data", rx[7:0], 8'hED);
    check("ed_parity", rx[8], 1);
    check("ed_stop", rx[9], 1);
    cycles(20);
    step();
    check("ed_done_once", done_cnt - d0, 1);
    check("ed_no_error", err_cnt - e0, 0);
    check("ed_busy_low", tx_busy, 0);
    check("ed_ready_high", tx_ready, 1);

    // back-to-back 0x01, 0x00
    for (int i = 0; i < 2; i++) begin
      d0 = done_cnt;
      send(bb_byte[i]);
      wait_request(len, ok);
      check("bb_request", ok, 1);
      check("bb_inhibit_ge120", len >= 120, 1);
      dev_frame(1'b0, rx);
      check("bb_data", rx[7:0], bb_byte[i]);
      check("bb_parity", rx[8], bb_par[i]);
      cycles(20);
      step();
      check("bb_done_once", done_cnt - d0, 1);
    end

    // NACK from the device
    d0 = done_cnt; e0 = err_cnt; ph0 = inh_phases;
    send(8'h5A);
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_request(len, ok);
      check("nack_request", ok, 1);
      dev_frame(1'b1, rx);
      check("nack_data", rx[7:0], 8'h5A);
    end
    cycles(20);
    step();
    check("nack_error_once", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);
    check("nack_inhibit_phases", inh_phases - ph0, ATTEMPTS);
    check("nack_ready", tx_ready, 1);
    check("nack_data_oe", ps2_data_oe, 0);

    // device never clocks: start timeout
    d0 = done_cnt; e0 = err_cnt; ph0 = inh_phases;
    send(8'h12);
    n = 0;
    while (err_cnt == e0 && n < START_CYC * ATTEMPTS + 2000) begin
      step();
      n++;
    end
    check("tmo_error_seen", err_cnt - e0, 1);
    check("tmo_latency", err_cyc - rel_cyc, START_CYC);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_data_oe", ps2_data_oe, 0);
    check("tmo_inhibit_phases", inh_phases - ph0, ATTEMPTS);
    cycles(5);
    step();
    check("tmo_no_done", done_cnt - d0, 0);
    check("tmo_ready", tx_ready, 1);

    // reset after edge 5, then a clean 0xFF
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5);
    wait_request(len, ok);
    check("rstmid_request", ok, 1);
    cycles(50);
    for (int k = 0; k < 4; k++) dev_bit(b);
    dev_clk_low = 1'b1;
    cycles(10);
    check("rstmid_pre_data_oe", ps2_data_oe, 1);
    @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    check("rstmid_clk_oe", ps2_clk_oe, 0);
    check("rstmid_data_oe", ps2_data_oe, 0);
    check("rstmid_ready", tx_ready, 1);
    cycles(3);
    dev_clk_low = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    cycles(10);
    step();
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_error", err_cnt - e0, 0);
    check("rstmid_busy", tx_busy, 0);
    send(8'hFF);
    wait_request(len, ok);
    check("ff_request", ok, 1);
    dev_frame(1'b0, rx);
    check("ff_data", rx[7:0], 8'hFF);
    check("ff_parity", rx[8], 1);
    cycles(20);
    step();
    check("ff_done_once", done_cnt - d0, 1);

    // tx_valid held high across a frame
    d0 = done_cnt; ph0 = inh_phases;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    wait_request(len, ok);
    check("hold_request", ok, 1);
    tx_data = 8'hC3;
    dev_frame(1'b0, rx);
    check("hold_data", rx[7:0], 8'h3C);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      step();
      n++;
    end
    check("hold_done_once", done_cnt - d0, 1);
    check("hold_single_inhibit", inh_phases - ph0, 1);
    step();
    check("hold_ready_returns", tx_ready, 1);
    step();
    check("hold_second_accept", tx_busy, 1);
    tx_valid = 1'b0;
    wait_request(len, ok);
    check("hold2_request", ok, 1);
    dev_frame(1'b0, rx);
    check("hold2_data", rx[7:0], 8'hC3);
    cycles(20);
    step();
    check("hold2_done_total", done_cnt - d0, 2);
    check("hold2_inhibit_total", inh_phases - ph0, 2);
    check("hold2_busy", tx_busy, 0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
